// File: rtl/cam_match_sequencer.sv
// Captures a CAM match-line vector and streams out the index of each set line in
// priority order over a valid/ready handshake; MULTI=0 emits only the winner.
module cam_match_sequencer #(
    parameter  int WIDTH      = 4,
    parameter  int MULTI      = 1,
    parameter  int HIGH_FIRST = 0,
    localparam int IW         = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_match,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IW-1:0]    out_index,
    output logic             out_hit,
    output logic             out_last,
    output logic             out_multi,
    output logic [IW:0]      out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_pend,  w_pend_nxt;
    logic [IW:0]      r_cnt,   w_cnt_nxt;
    logic             r_multi, w_multi_nxt;
    logic [IW:0]      w_in_cnt;
    logic [IW-1:0]    w_sel;
    logic             w_more;
    logic             w_last;

    function automatic logic [IW:0] f_popcount(input logic [WIDTH-1:0] v);
        logic [IW:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{IW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Last write wins, so the loop direction decides which set bit has priority.
    function automatic logic [IW-1:0] f_prio(input logic [WIDTH-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        if (HIGH_FIRST == 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (v[i]) idx = IW'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (v[i]) idx = IW'(i);
            end
        end
        return idx;
    endfunction

    assign w_in_cnt = f_popcount(in_match);
    assign w_sel    = f_prio(r_pend);
    assign w_more   = |(r_pend & (r_pend - WIDTH'(1)));
    assign w_last   = !w_more || (MULTI == 0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_cnt   <= '0;
            r_multi <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_cnt   <= w_cnt_nxt;
            r_multi <= w_multi_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_cnt_nxt   = r_cnt;
        w_multi_nxt = r_multi;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_index   = '0;
        out_hit     = 1'b0;
        out_last    = 1'b0;
        out_multi   = 1'b0;
        out_count   = '0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_pend_nxt  = in_match;
                    w_cnt_nxt   = w_in_cnt;
                    w_multi_nxt = (w_in_cnt > (IW+1)'(1));
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                out_valid = 1'b1;
                out_index = w_sel;
                out_hit   = |r_pend;
                out_last  = w_last;
                out_multi = r_multi;
                out_count = r_cnt;
                if (out_ready) begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                        w_pend_nxt  = '0;
                    end else begin
                        w_pend_nxt = r_pend & ~(WIDTH'(1) << w_sel);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
